// File: rtl/i2c_master_defines.sv
// Shared I2C master definitions: bit-controller command encodings.
// Used by both the byte controller and the bit controller so the command
// interface between them is decoded identically on both sides.
package i2c_master_defines;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// Purpose: byte sequencer turning host start/write/read/stop requests into
//          single-bit commands for the I2C bit controller.
// Latency: 8 data + 1 ACK bit commands (+START/+STOP); Cmd_ack 1 cycle after final Bit_ack.
// Backpressure: each bit command is held until Bit_ack; host must drop its request on Cmd_ack.
// Ports:
//   Clk, Rst_n                      clock, async active-low reset
//   Enable                          low forces idle/NOP, data registers held
//   Start/Stop/Read/Write, Ack_in   host request and ACK bit to send after a read
//   Din / Dout                      byte to send / byte received (mirrors shift register)
//   Cmd_ack, Ack_out, I2C_al        request done pulse, slave ACK, arbitration-lost pulse
//   Bit_cmd, Bit_txd                command and data bit to the bit controller
//   Bit_ack, Bit_rxd, Bit_al        completion, received bit, arbitration lost from it
module i2c_master_byte_ctrl
  import i2c_master_defines::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Enable,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Read,
  input  logic       Write,
  input  logic       Ack_in,
  input  logic [7:0] Din,
  output logic       Cmd_ack,
  output logic       Ack_out,
  output logic [7:0] Dout,
  output logic       I2C_al,
  output logic [3:0] Bit_cmd,
  output logic       Bit_txd,
  input  logic       Bit_ack,
  input  logic       Bit_rxd,
  input  logic       Bit_al
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t     state_q, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic [7:0] sr_q, sr_n;
  logic [3:0] cmd_q, cmd_n;
  logic       txd_q, txd_n;
  logic       cmd_ack_q, cmd_ack_n;
  logic       ack_out_q, ack_out_n;
  logic       al_q, al_n;
  logic       go;

  // Gating on Cmd_ack stops the still-asserted request from relaunching
  // in the cycle the host is told it has completed.
  assign go = (Read | Write | Stop) & ~cmd_ack_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      sr_q      <= 8'h00;
      cmd_q     <= I2C_CMD_NOP;
      txd_q     <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      al_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      sr_q      <= sr_n;
      cmd_q     <= cmd_n;
      txd_q     <= txd_n;
      cmd_ack_q <= cmd_ack_n;
      ack_out_q <= ack_out_n;
      al_q      <= al_n;
    end
  end

  always_comb begin
    // Command and data registers hold by default so Bit_cmd stays steady
    // between Bit_acks; only the pulses default low.
    state_n   = state_q;
    cnt_n     = cnt_q;
    sr_n      = sr_q;
    cmd_n     = cmd_q;
    txd_n     = txd_q;
    cmd_ack_n = 1'b0;
    ack_out_n = ack_out_q;
    al_n      = 1'b0;

    if (Bit_al) begin
      // Arbitration loss wins over everything, including a coincident Bit_ack.
      state_n = ST_IDLE;
      cmd_n   = I2C_CMD_NOP;
      txd_n   = 1'b0;
      al_n    = 1'b1;
    end else if (!Enable) begin
      state_n = ST_IDLE;
      cmd_n   = I2C_CMD_NOP;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            sr_n  = Din;
            cnt_n = 3'd7;
            if (Start) begin
              state_n = ST_START;
              cmd_n   = I2C_CMD_START;
            end else if (Read) begin
              state_n = ST_READ;
              cmd_n   = I2C_CMD_READ;
            end else if (Write) begin
              state_n = ST_WRITE;
              cmd_n   = I2C_CMD_WRITE;
              txd_n   = Din[7];
            end else begin
              state_n = ST_STOP;
              cmd_n   = I2C_CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (Bit_ack) begin
            if (Read) begin
              state_n = ST_READ;
              cmd_n   = I2C_CMD_READ;
            end else begin
              state_n = ST_WRITE;
              cmd_n   = I2C_CMD_WRITE;
              txd_n   = sr_q[7];
            end
          end
        end

        ST_WRITE, ST_READ: begin
          if (Bit_ack) begin
            sr_n = {sr_q[6:0], (state_q == ST_READ) ? Bit_rxd : 1'b0};
            if (cnt_q != 3'd0) begin
              cnt_n = cnt_q - 3'd1;
              txd_n = sr_n[7];
            end else begin
              state_n = ST_ACK;
              if (state_q == ST_WRITE) begin
                // After a write the master samples the slave's ACK.
                cmd_n = I2C_CMD_READ;
              end else begin
                // After a read the master drives its own ACK/NACK.
                cmd_n = I2C_CMD_WRITE;
                txd_n = Ack_in;
              end
            end
          end
        end

        ST_ACK: begin
          if (Bit_ack) begin
            ack_out_n = Bit_rxd;
            if (Stop) begin
              state_n = ST_STOP;
              cmd_n   = I2C_CMD_STOP;
            end else begin
              state_n   = ST_IDLE;
              cmd_n     = I2C_CMD_NOP;
              cmd_ack_n = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (Bit_ack) begin
            state_n   = ST_IDLE;
            cmd_n     = I2C_CMD_NOP;
            cmd_ack_n = 1'b1;
          end
        end

        default: begin
          state_n = ST_IDLE;
          cmd_n   = I2C_CMD_NOP;
        end
      endcase
    end
  end

  assign Cmd_ack = cmd_ack_q;
  assign Ack_out = ack_out_q;
  assign Dout    = sr_q;
  assign I2C_al  = al_q;
  assign Bit_cmd = cmd_q;
  assign Bit_txd = txd_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for the I2C byte controller: a simple bit-controller model answers
// each bit command after a few cycles, and byte requests are checked against
// hand-derived command/data sequences plus arbitration, reset and enable cases.
module tb_i2c_master_byte_ctrl;
  import i2c_master_defines::*;

  localparam logic [3:0] N = I2C_CMD_NOP;
  localparam logic [3:0] S = I2C_CMD_START;
  localparam logic [3:0] P = I2C_CMD_STOP;
  localparam logic [3:0] W = I2C_CMD_WRITE;
  localparam logic [3:0] R = I2C_CMD_READ;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Enable = 1'b1;
  logic       Start = 1'b0, Stop = 1'b0, Read = 1'b0, Write = 1'b0, Ack_in = 1'b0;
  logic [7:0] Din = 8'h00;
  logic       Cmd_ack, Ack_out, I2C_al, Bit_txd;
  logic [7:0] Dout;
  logic [3:0] Bit_cmd;
  logic       Bit_ack = 1'b0, Bit_rxd = 1'b0, Bit_al = 1'b0;

  i2c_master_byte_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .Start(Start), .Stop(Stop), .Read(Read), .Write(Write), .Ack_in(Ack_in),
    .Din(Din), .Cmd_ack(Cmd_ack), .Ack_out(Ack_out), .Dout(Dout), .I2C_al(I2C_al),
    .Bit_cmd(Bit_cmd), .Bit_txd(Bit_txd), .Bit_ack(Bit_ack), .Bit_rxd(Bit_rxd),
    .Bit_al(Bit_al)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             start, stop, rd, wr, ack_in;
    logic [7:0]       din;
    logic [8:0]       rx;     // bits returned on READ commands, MSB first
    int               n;      // expected number of bit commands
    logic [0:10][3:0] cmds;   // expected command sequence, NOP padded
    logic [0:10]      txd;    // expected Bit_txd, compared on WRITE commands
    logic [7:0]       dout;
    logic             ack_out;
  } vec_t;

  vec_t vecs[6];

  // Results of the bit-controller model
  logic [0:10][3:0] got_cmds;
  logic [0:10]      got_txd, got_mask;
  int               n_got, ack_lat;
  logic             got_cmd_ack, al_seen, timed_out;

  // Answers bit commands until Cmd_ack, I2C_al, a command budget or timeout.
  // Command number al_at (0-based) is acknowledged together with Bit_al.
  task automatic serve(input logic [8:0] rx, input int al_at, input int stop_after);
    int  cycles, dly, rptr, last_ack;
    logic done;
    n_got = 0; got_cmds = '0; got_txd = '0; got_mask = '0;
    got_cmd_ack = 0; al_seen = 0; timed_out = 0; ack_lat = -1;
    cycles = 0; dly = 0; rptr = 8; last_ack = 0; done = 0;
    while (!done) begin
      @(negedge Clk);
      cycles++;
      Bit_ack = 0; Bit_al = 0; Bit_rxd = 0;
      if (cycles > 400) begin
        timed_out = 1; done = 1;
      end else if (Cmd_ack) begin
        got_cmd_ack = 1; ack_lat = cycles - last_ack; done = 1;
      end else if (I2C_al) begin
        al_seen = 1; done = 1;
      end else if (stop_after >= 0 && n_got == stop_after) begin
        done = 1;
      end else if (Bit_cmd != N) begin
        dly++;
        if (dly == 3) begin
          dly = 0;
          if (n_got < 11) begin
            got_cmds[n_got] = Bit_cmd;
            got_txd[n_got]  = Bit_txd;
            got_mask[n_got] = (Bit_cmd == W);
          end
          if (Bit_cmd == R) begin
            Bit_rxd = rx[rptr];
            if (rptr > 0) rptr--;
          end else begin
            Bit_rxd = Bit_txd;  // bus echoes what the master drove
          end
          Bit_ack = 1;
          if (n_got == al_at) Bit_al = 1;
          n_got++;
          last_ack = cycles;
        end
      end
    end
    if (timed_out) begin
      checks++; failures++;
      $display("FAIL serve_timeout: got %0d commands, no completion", n_got);
    end
  endtask

  initial begin
    //            start stop rd  wr  ackin din    rx                 n   cmds                      txd                     dout   ack_out
    vecs[0] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'hA5, {1'b0,8'h00}, 10, {S,{8{W}},R,N},      {1'b0,8'hA5,2'b00}, 8'h00, 1'b0};
    vecs[1] = '{1'b0,1'b1,1'b1,1'b0,1'b1, 8'hFF, {8'h3C,1'b0}, 10, {{8{R}},W,P,N},      {8'h00,1'b1,2'b00}, 8'h3C, 1'b1};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 8'h5A, 9'h000,        1, {P,{10{N}}},         11'h000,            8'h5A, 1'b1};
    vecs[3] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, {1'b1,8'h00},  9, {{8{W}},R,N,N},      11'h000,            8'h00, 1'b1};
    vecs[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 8'h00, {8'hC3,1'b0}, 10, {S,{8{R}},W,N},      11'h000,            8'hC3, 1'b0};
    vecs[5] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 8'h81, {1'b0,8'h00}, 11, {S,{8{W}},R,P},      {1'b0,8'h81,2'b00}, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_bit_cmd", Bit_cmd, N);
    chk("rst_bit_txd", Bit_txd, 0);
    chk("rst_cmd_ack", Cmd_ack, 0);
    chk("rst_ack_out", Ack_out, 0);
    chk("rst_dout", Dout, 8'h00);
    chk("rst_i2c_al", I2C_al, 0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Table-driven byte requests, run back to back
    for (int i = 0; i < 6; i++) begin
      Start = vecs[i].start; Stop = vecs[i].stop; Read = vecs[i].rd;
      Write = vecs[i].wr; Ack_in = vecs[i].ack_in; Din = vecs[i].din;
      serve(vecs[i].rx, -1, -1);
      chk($sformatf("v%0d_cmd_ack", i), got_cmd_ack, 1);
      chk($sformatf("v%0d_ack_latency", i), ack_lat, 1);
      chk($sformatf("v%0d_n_cmds", i), n_got, vecs[i].n);
      chk($sformatf("v%0d_cmds", i), got_cmds, vecs[i].cmds);
      chk($sformatf("v%0d_txd", i), got_txd & got_mask, vecs[i].txd & got_mask);
      chk($sformatf("v%0d_dout", i), Dout, vecs[i].dout);
      chk($sformatf("v%0d_ack_out", i), Ack_out, vecs[i].ack_out);
      // Request still held across the Cmd_ack cycle: must not relaunch
      @(negedge Clk);
      chk($sformatf("v%0d_no_relaunch", i), Bit_cmd, N);
      chk($sformatf("v%0d_cmd_ack_pulse", i), Cmd_ack, 0);
      Start = 0; Stop = 0; Read = 0; Write = 0; Ack_in = 0;
      @(negedge Clk);
    end

    // Arbitration lost together with the Bit_ack of data bit 4 (command 5)
    Start = 1; Write = 1; Din = 8'hFF;
    serve(9'h000, 5, -1);
    chk("al_seen", al_seen, 1);
    chk("al_n_cmds", n_got, 6);
    chk("al_bit_cmd", Bit_cmd, N);
    chk("al_bit_txd", Bit_txd, 0);
    chk("al_no_cmd_ack", Cmd_ack, 0);
    Start = 0; Write = 0;
    @(negedge Clk);
    chk("al_pulse_one_cycle", I2C_al, 0);
    chk("al_idle_nop", Bit_cmd, N);

    // Asynchronous reset in the middle of a read
    Read = 1; Din = 8'hFF; Ack_in = 0;
    serve(9'h1FF, -1, 3);
    chk("pre_rst_cmd_read", Bit_cmd, R);
    chk("pre_rst_dout", Dout, 8'hFF);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_bit_cmd", Bit_cmd, N);
    chk("mid_rst_bit_txd", Bit_txd, 0);
    chk("mid_rst_dout", Dout, 8'h00);
    chk("mid_rst_cmd_ack", Cmd_ack, 0);
    chk("mid_rst_ack_out", Ack_out, 0);
    chk("mid_rst_i2c_al", I2C_al, 0);
    Read = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Enable dropped in the middle of a write: idle/NOP, data held
    Write = 1; Din = 8'hFF;
    serve(9'h000, -1, 3);
    chk("pre_en_cmd_write", Bit_cmd, W);
    Enable = 0;
    @(negedge Clk);
    chk("en_low_nop", Bit_cmd, N);
    chk("en_low_cmd_ack", Cmd_ack, 0);
    chk("en_low_dout_held", Dout, 8'hF8);
    @(negedge Clk);
    chk("en_low_no_launch", Bit_cmd, N);
    Write = 0; Enable = 1;
    repeat (2) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
